// File: rtl/alu_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_vector_sequencer
// Description : Walks a 32-bit multifunction ALU through 64 test vectors
//               (8 operand sets x 8 ops). Drives AA/BB/ALU_OP, waits for
//               the result to settle, then registers F/ZF/OF for display.
//               Advances on a STEP button or automatically after a hold time.
//               Optional macro ALU_SEQ_SIGNATURE_EN enables a rotating-XOR
//               result signature on o_sig; otherwise o_sig is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_vector_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 50_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_step,
    input  logic        i_auto,
    input  logic [31:0] i_f,
    input  logic        i_zf,
    input  logic        i_of,
    output logic [31:0] o_aa,
    output logic [31:0] o_bb,
    output logic [2:0]  o_alu_op,
    output logic [5:0]  o_idx,
    output logic [31:0] o_res,
    output logic        o_res_zf,
    output logic        o_res_of,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_sig
);

    // Counter widths; both are at least one bit even for degenerate settings.
    localparam int c_SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int c_HOLD_W   = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LOAD = c_SETTLE_W'(SETTLE_CYCLES);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_ONE  = c_SETTLE_W'(1);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST   = c_HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t                r_state;
    logic [2:0]            r_start_sync;   // [0],[1] synchroniser, [2] edge history
    logic [2:0]            r_step_sync;
    logic [1:0]            r_auto_sync;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [5:0]            r_idx;
    logic [31:0]           r_aa;
    logic [31:0]           r_bb;
    logic [2:0]            r_alu_op;
    logic [31:0]           r_res;
    logic                  r_res_zf;
    logic                  r_res_of;
    logic                  r_busy;
    logic                  r_done;
`ifdef ALU_SEQ_SIGNATURE_EN
    logic [31:0]           r_sig;
`endif

    logic w_start_edge;
    logic w_step_edge;
    logic w_auto;

    assign w_start_edge = r_start_sync[1] & ~r_start_sync[2];
    assign w_step_edge  = r_step_sync[1]  & ~r_step_sync[2];
    assign w_auto       = r_auto_sync[1];

    // Operand table indexed by IDX[5:3]; packed as {AA, BB}.
    function automatic logic [63:0] f_operands(input logic [2:0] i_set);
        case (i_set)
            3'd0:    f_operands = {32'h0000_0000, 32'h0000_0000};
            3'd1:    f_operands = {32'h0000_0003, 32'h0000_0607};
            3'd2:    f_operands = {32'h8000_0000, 32'h8000_0000};
            3'd3:    f_operands = {32'h7FFF_FFFF, 32'h7FFF_FFFF};
            3'd4:    f_operands = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
            3'd5:    f_operands = {32'h8000_0000, 32'hFFFF_FFFF};
            3'd6:    f_operands = {32'h1234_5678, 32'h3333_2222};
            default: f_operands = {32'h9ABC_DEF0, 32'h1111_2222};
        endcase
    endfunction

    // Button/switch synchronisers with edge-history stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_sync <= '0;
            r_step_sync  <= '0;
            r_auto_sync  <= '0;
        end else begin
            r_start_sync <= {r_start_sync[1:0], i_start};
            r_step_sync  <= {r_step_sync[1:0], i_step};
            r_auto_sync  <= {r_auto_sync[0], i_auto};
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_hold_cnt   <= '0;
            r_idx        <= '0;
            r_aa         <= '0;
            r_bb         <= '0;
            r_alu_op     <= '0;
            r_res        <= '0;
            r_res_zf     <= 1'b0;
            r_res_of     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef ALU_SEQ_SIGNATURE_EN
            r_sig        <= '0;
`endif
        end else begin
            case (r_state)
                // START is only honoured when no run is in progress.
                S_IDLE, S_FINISH: begin
                    if (w_start_edge) begin
                        r_idx   <= '0;
                        r_done  <= 1'b0;
`ifdef ALU_SEQ_SIGNATURE_EN
                        r_sig   <= '0;
`endif
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    {r_aa, r_bb}  <= f_operands(r_idx[5:3]);
                    r_alu_op      <= r_idx[2:0];
                    r_busy        <= 1'b1;
                    r_settle_cnt  <= c_SETTLE_LOAD;
                    r_state       <= (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle_cnt <= c_SETTLE_ONE) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - c_SETTLE_ONE;
                    end
                end
                S_CAPTURE: begin
                    r_res      <= i_f;
                    r_res_zf   <= i_zf;
                    r_res_of   <= i_of;
`ifdef ALU_SEQ_SIGNATURE_EN
                    r_sig      <= {r_sig[30:0], r_sig[31]} ^ i_f ^ {30'b0, i_of, i_zf};
`endif
                    r_hold_cnt <= '0;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_step_edge || (w_auto && (r_hold_cnt == c_HOLD_LAST))) begin
                        r_hold_cnt <= '0;
                        if (r_idx == 6'd63) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_idx   <= r_idx + 6'd1;
                            r_state <= S_ISSUE;
                        end
                    end else if (!w_auto) begin
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_aa     = r_aa;
    assign o_bb     = r_bb;
    assign o_alu_op = r_alu_op;
    assign o_idx    = r_idx;
    assign o_res    = r_res;
    assign o_res_zf = r_res_zf;
    assign o_res_of = r_res_of;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
`ifdef ALU_SEQ_SIGNATURE_EN
    assign o_sig    = r_sig;
`else
    assign o_sig    = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_vector_sequencer
// Description : Scoreboard bench for alu_vector_sequencer. Stimulus queues
//               the expected per-vector response; a monitor pops and checks
//               each vector the DUT presents, including capture timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_vector_sequencer;

    localparam int SETTLE = 2;
    localparam int HOLD   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        auto_sw = 1'b0;
    logic [31:0] f;
    logic        zf;
    logic        of;
    logic [31:0] aa, bb, res, sig;
    logic [2:0]  alu_op;
    logic [5:0]  idx;
    logic        res_zf, res_of, busy, done;

    always #5 clk = ~clk;

    // Bench ALU model
    assign f  = aa ^ bb;
    assign zf = (f == 32'h0);
    assign of = 1'b0;

    alu_vector_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_step  (step),
        .i_auto  (auto_sw),
        .i_f     (f),
        .i_zf    (zf),
        .i_of    (of),
        .o_aa    (aa),
        .o_bb    (bb),
        .o_alu_op(alu_op),
        .o_idx   (idx),
        .o_res   (res),
        .o_res_zf(res_zf),
        .o_res_of(res_of),
        .o_busy  (busy),
        .o_done  (done),
        .o_sig   (sig)
    );

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [31:0] res;
        logic        zf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    function automatic logic [63:0] tb_ops(input logic [2:0] s);
        case (s)
            3'd0:    tb_ops = {32'h0000_0000, 32'h0000_0000};
            3'd1:    tb_ops = {32'h0000_0003, 32'h0000_0607};
            3'd2:    tb_ops = {32'h8000_0000, 32'h8000_0000};
            3'd3:    tb_ops = {32'h7FFF_FFFF, 32'h7FFF_FFFF};
            3'd4:    tb_ops = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
            3'd5:    tb_ops = {32'h8000_0000, 32'hFFFF_FFFF};
            3'd6:    tb_ops = {32'h1234_5678, 32'h3333_2222};
            default: tb_ops = {32'h9ABC_DEF0, 32'h1111_2222};
        endcase
    endfunction

    function automatic exp_t mk_exp(input int i);
        exp_t        e;
        logic [63:0] ops;
        e.idx = 6'(i);
        ops   = tb_ops(e.idx[5:3]);
        e.aa  = ops[63:32];
        e.bb  = ops[31:0];
        e.res = e.aa ^ e.bb;
        e.zf  = (e.res == 32'h0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle high pulse on START (sel=0) or STEP (sel=1).
    task automatic pulse(input int sel);
        if (sel == 0) start = 1'b1; else step = 1'b1;
        tick(1);
        start = 1'b0;
        step  = 1'b0;
    endtask

    task automatic wait_idx(input logic [5:0] t, input string name);
        int n = 0;
        while (idx !== t && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(idx), 32'(t));
    endtask

    // Monitor: each newly presented vector pops one expectation.
    initial begin : monitor
        logic        prev_busy;
        logic [5:0]  prev_idx;
        logic [31:0] old_res;
        exp_t        e;
        prev_busy = 1'b0;
        prev_idx  = '0;
        forever begin
            @(negedge clk);
            if (mon_en && busy && (!prev_busy || idx != prev_idx)) begin
                // Operands load one cycle after ISSUE entry.
                if (prev_busy) @(negedge clk);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got vector idx %0d want none queued", idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_idx",  32'(idx),    32'(e.idx));
                    chk("sb_aa",   aa,          e.aa);
                    chk("sb_bb",   bb,          e.bb);
                    chk("sb_op",   32'(alu_op), 32'(e.idx[2:0]));
                    chk("sb_busy", 32'(busy),   32'd1);
                    old_res = res;
                    repeat (2) @(negedge clk);
                    if (e.res != old_res) chk("sb_res_early", res, old_res);
                    @(negedge clk);
                    chk("sb_res",    res,         e.res);
                    chk("sb_res_zf", 32'(res_zf), 32'(e.zf));
                    chk("sb_res_of", 32'(res_of), 32'd0);
                end
            end
            prev_busy = busy;
            prev_idx  = idx;
        end
    end

    // Stimulus
    initial begin : stimulus
        int          cyc;
        logic [31:0] golden;
        exp_t        g;

        // Reset state
        tick(3);
        chk("rst_aa",   aa,          32'h0);
        chk("rst_busy", 32'(busy),   32'd0);
        chk("rst_done", 32'(done),   32'd0);
        chk("rst_idx",  32'(idx),    32'd0);
        chk("rst_res",  res,         32'h0);
        chk("rst_sig",  sig,         32'h0);
        rst_n = 1'b1;
        tick(10);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // Manual stepping through vectors 0..16
        auto_sw = 1'b0;
        mon_en  = 1'b1;
        exp_q.push_back(mk_exp(0));
        pulse(0);
        cyc = 0;
        while (!busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("start_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            tick(6);
            if (k == 9) begin
                chk("cap8_res", res,         32'h0000_0604);
                chk("cap8_zf",  32'(res_zf), 32'd0);
            end
            exp_q.push_back(mk_exp(k));
            pulse(1);
            wait_idx(6'(k), "step_idx");
            if (k == 3) begin
                tick(1);
                chk("step3_op", 32'(alu_op), 32'd3);
            end
        end
        tick(6);
        chk("cap16_res", res,         32'h0);
        chk("cap16_zf",  32'(res_zf), 32'd1);

        // START mid-run is ignored
        pulse(0);
        tick(8);
        chk("start_midrun_idx",  32'(idx),  32'd16);
        chk("start_midrun_busy", 32'(busy), 32'd1);

        // STEP landing in SETTLE is ignored
        exp_q.push_back(mk_exp(17));
        pulse(1);
        wait_idx(6'd17, "step17_idx");
        pulse(1);
        tick(12);
        chk("step_in_settle_idx", 32'(idx), 32'd17);

        // Reset while in SETTLE clears everything immediately
        mon_en = 1'b0;
        pulse(1);
        wait_idx(6'd18, "step18_idx");
        tick(1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_aa",   aa,          32'h0);
        chk("abort_bb",   bb,          32'h0);
        chk("abort_op",   32'(alu_op), 32'd0);
        chk("abort_idx",  32'(idx),    32'd0);
        chk("abort_busy", 32'(busy),   32'd0);
        chk("abort_done", 32'(done),   32'd0);
        chk("abort_sig",  sig,         32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("post_abort_busy", 32'(busy), 32'd0);

        // Full auto run
        auto_sw = 1'b1;
        tick(4);
        golden = 32'h0;
        for (int i = 0; i < 64; i++) begin
            g = mk_exp(i);
            exp_q.push_back(g);
            golden = {golden[30:0], golden[31]} ^ g.res ^ {31'b0, g.zf};
        end
        mon_en = 1'b1;
        start  = 1'b1;
        cyc    = 0;
        while (!done && cyc < 700) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        chk("auto_cycles", 32'(cyc),    32'd515);
        chk("auto_done",   32'(done),   32'd1);
        chk("auto_busy",   32'(busy),   32'd0);
        chk("auto_idx",    32'(idx),    32'd63);
        chk("auto_aa",     aa,          32'h9ABC_DEF0);
        chk("auto_bb",     bb,          32'h1111_2222);
        chk("auto_op",     32'(alu_op), 32'd7);
`ifdef ALU_SEQ_SIGNATURE_EN
        chk("auto_sig",    sig,         golden);
`else
        chk("auto_sig",    sig,         32'h0);
`endif

        // Restart from FINISH
        auto_sw = 1'b0;
        exp_q.push_back(mk_exp(0));
        pulse(0);
        tick(3);
        chk("restart_idx",  32'(idx),  32'd0);
        chk("restart_done", 32'(done), 32'd0);
        tick(8);
`ifdef ALU_SEQ_SIGNATURE_EN
        chk("restart_sig", sig, 32'h0000_0001);
`else
        chk("restart_sig", sig, 32'h0);
`endif
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
